// File: rtl/interrupt_arbiter_pkg.sv
// Shared CSR types for machine-mode interrupt handling: mip/mie layouts,
// privilege encoding, mcause code width and the interrupt code constants.
package interrupt_arbiter_pkg;

  // Width of the mcause exception/interrupt code field
  localparam int ECODE_W = 5;

  // mcause interrupt codes for the three machine-level sources
  localparam logic [ECODE_W-1:0] M_SOFTWARE_INT = ECODE_W'(3);
  localparam logic [ECODE_W-1:0] M_TIMER_INT    = ECODE_W'(7);
  localparam logic [ECODE_W-1:0] M_EXTERNAL_INT = ECODE_W'(11);

  // Privilege level encoding as held in mstatus.MPP
  typedef enum logic [1:0] {
    USER_PRIVILEGE       = 2'b00,
    SUPERVISOR_PRIVILEGE = 2'b01,
    MACHINE_PRIVILEGE    = 2'b11
  } privilege_t;

  // mip CSR layout: meip bit 11, mtip bit 7, msip bit 3
  typedef struct packed {
    logic [19:0] rsvdHi;
    logic        meip;
    logic [2:0]  rsvd10to8;
    logic        mtip;
    logic [2:0]  rsvd6to4;
    logic        msip;
    logic [2:0]  rsvd2to0;
  } mip_t;

  // mie CSR layout, mirroring mip bit positions
  typedef struct packed {
    logic [19:0] rsvdHi;
    logic        meie;
    logic [2:0]  rsvd10to8;
    logic        mtie;
    logic [2:0]  rsvd6to4;
    logic        msie;
    logic [2:0]  rsvd2to0;
  } mie_t;

endpackage

// File: rtl/interrupt_sync.sv
// Multi-flop synchronizer for one raw interrupt level line.
module interrupt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_stages;

  // Shift the raw level through the chain; the last stage is the clean copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_arbiter.sv
// Machine-mode interrupt arbiter: synchronizes the raw lines, masks them with
// mie and the global enable, and offers one interrupt at a time to the pipeline.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_ext_irq,
  input  logic               m_timer_irq,
  input  logic               m_soft_irq,
  input  mie_t               mie,
  input  logic               mstatus_mie,
  input  privilege_t         privilege,
  input  logic               irq_block,
  input  logic               irq_ack,
  output mip_t               mip,
  output logic               irq_req,
  output logic [ECODE_W-1:0] irq_code
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_COOLDOWN
  } state_t;

  state_t             r_state;
  logic               r_irqReq;
  logic [ECODE_W-1:0] r_irqCode;

  logic               w_extSync;
  logic               w_timerSync;
  logic               w_softSync;
  mip_t               w_mip;
  logic               w_enExt;
  logic               w_enTimer;
  logic               w_enSoft;
  logic               w_anyEn;
  logic               w_globalEn;
  logic [ECODE_W-1:0] w_selCode;
  logic               w_latchedEn;
  logic               w_unusedMie;

  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncExt (
    .clk(clk), .rst(rst), .i_async(m_ext_irq), .o_sync(w_extSync)
  );

  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncTimer (
    .clk(clk), .rst(rst), .i_async(m_timer_irq), .o_sync(w_timerSync)
  );

  interrupt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncSoft (
    .clk(clk), .rst(rst), .i_async(m_soft_irq), .o_sync(w_softSync)
  );

  // Pending bits come straight from the synchronizer outputs
  always_comb begin
    w_mip      = '0;
    w_mip.meip = w_extSync;
    w_mip.mtip = w_timerSync;
    w_mip.msip = w_softSync;
  end

  assign mip         = w_mip;
  assign w_enExt     = w_mip.meip & mie.meie;
  assign w_enTimer   = w_mip.mtip & mie.mtie;
  assign w_enSoft    = w_mip.msip & mie.msie;
  assign w_anyEn     = w_enExt | w_enTimer | w_enSoft;
  assign w_globalEn  = mstatus_mie | (privilege != MACHINE_PRIVILEGE);
  assign w_unusedMie = ^{mie.rsvdHi, mie.rsvd10to8, mie.rsvd6to4, mie.rsvd2to0};

  // Fixed priority: external over software over timer
  always_comb begin
    w_selCode = M_TIMER_INT;
    if (w_enExt) begin
      w_selCode = M_EXTERNAL_INT;
    end else if (w_enSoft) begin
      w_selCode = M_SOFTWARE_INT;
    end
  end

  // Whether the source behind the code currently on offer is still enabled
  always_comb begin
    w_latchedEn = 1'b0;
    case (r_irqCode)
      M_EXTERNAL_INT: w_latchedEn = w_enExt;
      M_SOFTWARE_INT: w_latchedEn = w_enSoft;
      M_TIMER_INT:    w_latchedEn = w_enTimer;
      default:        w_latchedEn = 1'b0;
    endcase
  end

  // Offer FSM: latch a code in IDLE, hold it in REQ until ack or withdraw,
  // then idle for one cycle so the trap's mstatus.mie clear takes effect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_irqReq  <= 1'b0;
      r_irqCode <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyEn && w_globalEn && !irq_block) begin
            r_state   <= ST_REQ;
            r_irqReq  <= 1'b1;
            r_irqCode <= w_selCode;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_state   <= ST_COOLDOWN;
            r_irqReq  <= 1'b0;
            r_irqCode <= '0;
          end else if (!w_latchedEn || !w_globalEn) begin
            r_state   <= ST_IDLE;
            r_irqReq  <= 1'b0;
            r_irqCode <= '0;
          end
        end
        ST_COOLDOWN: begin
          r_state   <= ST_IDLE;
          r_irqReq  <= 1'b0;
          r_irqCode <= '0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irqReq  <= 1'b0;
          r_irqCode <= '0;
        end
      endcase
    end
  end

  assign irq_req  = r_irqReq;
  assign irq_code = r_irqCode;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed testbench for interrupt_arbiter with SYNC_STAGES=2.
module tb_interrupt_arbiter;
  import interrupt_arbiter_pkg::*;

  logic               clk;
  logic               rst;
  logic               m_ext_irq;
  logic               m_timer_irq;
  logic               m_soft_irq;
  logic [31:0]        mie;
  logic               mstatus_mie;
  privilege_t         privilege;
  logic               irq_block;
  logic               irq_ack;
  logic [31:0]        mip;
  logic               irq_req;
  logic [ECODE_W-1:0] irq_code;

  int errors = 0;
  int checks = 0;

  interrupt_arbiter #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .m_ext_irq(m_ext_irq),
    .m_timer_irq(m_timer_irq),
    .m_soft_irq(m_soft_irq),
    .mie(mie),
    .mstatus_mie(mstatus_mie),
    .privilege(privilege),
    .irq_block(irq_block),
    .irq_ack(irq_ack),
    .mip(mip),
    .irq_req(irq_req),
    .irq_code(irq_code)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n clock cycles; inputs change and outputs are sampled on falling edges
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check the offer outputs together
  task automatic checkOffer(input string tag, input logic expReq, input logic [31:0] expCode);
    checkOutput({tag, "_req"}, {31'd0, irq_req}, {31'd0, expReq});
    checkOutput({tag, "_code"}, 32'(irq_code), expCode);
  endtask

  // Linear sequence of directed steps
  initial begin
    rst         = 1'b1;
    m_ext_irq   = 1'b0;
    m_timer_irq = 1'b0;
    m_soft_irq  = 1'b0;
    mie         = 32'h0;
    mstatus_mie = 1'b0;
    privilege   = MACHINE_PRIVILEGE;
    irq_block   = 1'b0;
    irq_ack     = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOffer("reset", 1'b0, 32'd0);
    checkOutput("reset_mip", mip, 32'h0);
    rst = 1'b0;
    applyStimulus(1);

    // Timer offer latency: code 7 after exactly three edges
    mie         = 32'h080;
    mstatus_mie = 1'b1;
    m_timer_irq = 1'b1;
    applyStimulus(2);
    checkOffer("timer_early", 1'b0, 32'd0);
    checkOutput("timer_mip_early", mip, 32'h080);
    applyStimulus(1);
    checkOffer("timer_offer", 1'b1, 32'd7);
    checkOutput("timer_mip", mip, 32'h080);

    // Withdraw when the timer line drops without an ack
    m_timer_irq = 1'b0;
    applyStimulus(1);
    checkOffer("withdraw_hold1", 1'b1, 32'd7);
    applyStimulus(1);
    checkOutput("withdraw_mip_clear", mip, 32'h0);
    applyStimulus(1);
    checkOffer("withdraw_drop", 1'b0, 32'd0);
    irq_ack = 1'b1;
    applyStimulus(2);
    irq_ack = 1'b0;
    checkOffer("withdraw_stays", 1'b0, 32'd0);

    // Priority with all three lines high, ack, then software after external drops
    mie         = 32'h888;
    m_ext_irq   = 1'b1;
    m_timer_irq = 1'b1;
    m_soft_irq  = 1'b1;
    applyStimulus(3);
    checkOffer("prio_ext", 1'b1, 32'd11);
    checkOutput("prio_mip", mip, 32'h888);
    irq_ack   = 1'b1;
    m_ext_irq = 1'b0;
    applyStimulus(1);
    irq_ack = 1'b0;
    checkOffer("prio_cooldown", 1'b0, 32'd0);
    applyStimulus(1);
    checkOffer("prio_idle", 1'b0, 32'd0);
    applyStimulus(1);
    checkOffer("prio_soft", 1'b1, 32'd3);
    m_timer_irq = 1'b0;
    m_soft_irq  = 1'b0;
    mie         = 32'h0;
    applyStimulus(4);
    checkOffer("prio_clean", 1'b0, 32'd0);

    // A higher-priority source arriving does not preempt an offer
    mie         = 32'h888;
    m_timer_irq = 1'b1;
    applyStimulus(3);
    checkOffer("nopre_timer", 1'b1, 32'd7);
    m_ext_irq = 1'b1;
    applyStimulus(3);
    checkOffer("nopre_keep", 1'b1, 32'd7);
    irq_ack = 1'b1;
    applyStimulus(1);
    irq_ack = 1'b0;
    checkOffer("nopre_cooldown", 1'b0, 32'd0);
    applyStimulus(2);
    checkOffer("nopre_ext", 1'b1, 32'd11);
    m_ext_irq   = 1'b0;
    m_timer_irq = 1'b0;
    mie         = 32'h0;
    applyStimulus(4);
    checkOffer("nopre_clean", 1'b0, 32'd0);

    // Global enable: user mode ignores mstatus.mie, machine mode honours it
    mstatus_mie = 1'b0;
    privilege   = USER_PRIVILEGE;
    mie         = 32'h800;
    m_ext_irq   = 1'b1;
    applyStimulus(3);
    checkOffer("user_offer", 1'b1, 32'd11);
    privilege = MACHINE_PRIVILEGE;
    applyStimulus(1);
    checkOffer("machine_withdraw", 1'b0, 32'd0);
    applyStimulus(2);
    checkOffer("machine_masked", 1'b0, 32'd0);
    mstatus_mie = 1'b1;
    applyStimulus(1);
    checkOffer("machine_enabled", 1'b1, 32'd11);

    // Ack beats a simultaneous withdraw: cooldown delays the next offer
    irq_ack     = 1'b1;
    mstatus_mie = 1'b0;
    applyStimulus(1);
    irq_ack     = 1'b0;
    mstatus_mie = 1'b1;
    checkOffer("ackwin_first", 1'b0, 32'd0);
    applyStimulus(1);
    checkOffer("ackwin_cooldown", 1'b0, 32'd0);
    applyStimulus(1);
    checkOffer("ackwin_reoffer", 1'b1, 32'd11);
    m_ext_irq = 1'b0;
    mie       = 32'h0;
    applyStimulus(4);
    checkOffer("ackwin_clean", 1'b0, 32'd0);

    // irq_block holds off a new offer but not an existing one
    irq_block  = 1'b1;
    mie        = 32'h008;
    m_soft_irq = 1'b1;
    applyStimulus(4);
    checkOffer("block_hold", 1'b0, 32'd0);
    irq_block = 1'b0;
    applyStimulus(1);
    checkOffer("block_release", 1'b1, 32'd3);
    irq_block = 1'b1;
    applyStimulus(2);
    checkOffer("block_inreq", 1'b1, 32'd3);
    irq_block = 1'b0;

    // Reset mid-offer drops the request immediately and refills the synchronizers
    rst = 1'b1;
    #1;
    checkOffer("rst_async", 1'b0, 32'd0);
    checkOutput("rst_mip", mip, 32'h0);
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(2);
    checkOffer("rst_refill", 1'b0, 32'd0);
    applyStimulus(1);
    checkOffer("rst_reoffer", 1'b1, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops per raw interrupt line (legal range 2..4).
REQ-002 SHALL have port clk, input, 1: the single clock; all flops on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports m_ext_irq, m_timer_irq, m_soft_irq, input, 1 each: raw level interrupt lines, asynchronous to clk.
REQ-005 SHALL have port mie, input, 32: current mie CSR value (mie_t layout).
REQ-006 SHALL have port mstatus_mie, input, 1: global machine interrupt enable.
REQ-007 SHALL have port privilege, input, 2: current privilege level (privilege_t encoding).
REQ-008 SHALL have port irq_block, input, 1: pipeline cannot accept an interrupt this cycle.
REQ-009 SHALL have port irq_ack, input, 1: pipeline has taken the offered interrupt.
REQ-010 SHALL have port mip, output, 32: pending bits in mip_t layout; only meip/mtip/msip may be nonzero.
REQ-011 SHALL have port irq_req, output, 1: interrupt offered to pipeline.
REQ-012 SHALL have port irq_code, output, ECODE_W: mcause code of the offered interrupt.

Function
REQ-013 SHALL synchronize each raw line through SYNC_STAGES flops; mip.meip/mtip/msip SHALL equal the last-stage outputs.
REQ-014 SHALL compute enabled = mip & mie (meip&meie, mtip&mtie, msip&msie).
REQ-015 SHALL compute global_en = mstatus_mie OR (privilege != MACHINE_PRIVILEGE).
REQ-016 SHALL select by fixed priority: external (code 11) > software (code 3) > timer (code 7).
REQ-017 SHALL implement FSM states IDLE, REQ, COOLDOWN.
REQ-018 IDLE: if any enabled bit and global_en and !irq_block, SHALL latch the selected code and go to REQ next cycle; otherwise SHALL stay in IDLE.
REQ-019 REQ: irq_req SHALL be 1 and irq_code SHALL hold the latched value, constant for the whole state.
REQ-020 REQ with irq_ack=1: SHALL go to COOLDOWN; ack takes precedence over a simultaneous withdraw condition.
REQ-021 REQ with irq_ack=0 and either the latched source no longer enabled or global_en=0: SHALL withdraw to IDLE, dropping irq_req next cycle.
REQ-022 REQ with irq_ack=0, a higher-priority source newly enabled, and the latched source still enabled: SHALL keep the latched code (no preemption of an offer).
REQ-023 irq_block SHALL NOT affect an offer already in REQ.
REQ-024 COOLDOWN: irq_req SHALL be 0; SHALL return to IDLE after exactly one cycle so the trap's mstatus.mie clear is visible before re-arbitration.
REQ-025 irq_ack outside REQ SHALL be ignored.
REQ-026 Latency: raw line rising to irq_req=1 SHALL be SYNC_STAGES+1 cycles when enables are set and irq_block=0.
REQ-027 irq_code SHALL read 0 whenever irq_req=0.

Reset
REQ-028 While rst=1: all synchronizer flops 0, FSM IDLE, mip=0, irq_req=0, irq_code=0.
REQ-029 Reset asserted mid-offer (REQ/COOLDOWN) SHALL drop irq_req asynchronously; after release, arbitration SHALL restart from IDLE with synchronizers refilled (no stale offer).

Structure
REQ-030 Interrupt code constants (M_SOFTWARE_INT=3, M_TIMER_INT=7, M_EXTERNAL_INT=11) SHALL be added to the shared CSR types package; mip_t, mie_t, privilege_t, ECODE_W SHALL be reused from the shared packages.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 One sub-module, interrupt_sync (parameterized SYNC_STAGES, single bit, async reset), SHALL be instantiated once per raw line.

Verification
REQ-033 m_timer_irq 0->1, mie.mtie=1, mstatus_mie=1 -> irq_req=1 with irq_code=7 exactly 3 cycles later (SYNC_STAGES=2); mip=0x080.
REQ-034 All three lines high, all enabled -> irq_code=11; ack -> COOLDOWN 1 cycle; drop m_ext_irq -> next offer irq_code=3.
REQ-035 Offer code 7 pending, deassert m_timer_irq without ack -> irq_req falls within 1 cycle after mip.mtip clears; no ack-able offer remains.
REQ-036 mstatus_mie=0, privilege=USER, meie=1, m_ext_irq=1 -> irq_req=1, code 11; same with privilege=MACHINE -> irq_req stays 0.
REQ-037 irq_block=1 with enabled source -> irq_req stays 0; release irq_block -> irq_req=1 next cycle.
REQ-038 rst=1 asserted while irq_req=1 -> irq_req=0 immediately, mip=0; after release with line still high -> irq_req=1 after SYNC_STAGES+1 cycles.
